// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: req/ack fetch from program memory into a small prefetch FIFO,
// presents instr/pc with valid/ready and flushes on branch/jump redirects.
module instr_fetch_unit #(
   parameter int                          INSTR_ADDR_WIDTH = 8,
   parameter int                          FIFO_DEPTH       = 2,
   parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [31:0]                 instr,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   input  logic                        redirect,
   input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
   output logic                        mem_req,
   output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
   input  logic                        mem_ack,
   input  logic [31:0]                 mem_rdata,
   output logic                        pc_end
);

   localparam int W  = INSTR_ADDR_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          active_q, busy_q, discard_q;
   logic [W-1:0]  fetch_addr_q, req_addr_q;
   logic [31:0]   data_q [FIFO_DEPTH];
   logic [W-1:0]  pc_q   [FIFO_DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   logic          can_issue, ack, push, pop, busy_nxt;

   // A new request needs a free slot; the single outstanding one already owns a slot.
   assign can_issue   = active_q && (state_q == S_FETCH) && !busy_q &&
                        (count_q < CW'(FIFO_DEPTH));
   assign mem_req     = busy_q || can_issue;
   assign mem_addr    = busy_q ? req_addr_q : fetch_addr_q;
   assign ack         = mem_req && mem_ack;
   assign busy_nxt    = mem_req && !mem_ack;
   assign push        = ack && !discard_q && !redirect;
   assign instr_valid = (count_q != '0);
   assign pop         = instr_valid && instr_ready && !redirect;
   assign instr       = instr_valid ? data_q[rd_q] : '0;
   assign instr_pc    = instr_valid ? pc_q[rd_q]   : '0;
   assign pc_end      = (state_q == S_DONE) && (count_q == '0) && !busy_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_comb begin
      state_d = state_q;
      if (redirect)
         state_d = S_FETCH;
      else if (push && (mem_addr == '1))
         state_d = S_DONE;
      else begin
         case (state_q)
            S_FETCH: if ((count_d + {{(CW-1){1'b0}}, busy_nxt}) == CW'(FIFO_DEPTH))
                        state_d = S_WAIT;
            S_WAIT:  if (pop) state_d = S_FETCH;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         active_q     <= 1'b0;
         busy_q       <= 1'b0;
         discard_q    <= 1'b0;
         fetch_addr_q <= RESET_PC;
         req_addr_q   <= RESET_PC;
         rd_q         <= '0;
         wr_q         <= '0;
         count_q      <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= 1'b1;
         busy_q   <= busy_nxt;
         if (busy_nxt) req_addr_q <= mem_addr;
         // An in-flight request cannot be cancelled, so its eventual ack is dropped.
         if (redirect)  discard_q <= busy_nxt;
         else if (ack)  discard_q <= 1'b0;
         if (redirect)  fetch_addr_q <= redirect_pc;
         else if (push) fetch_addr_q <= fetch_addr_q + W'(1);
         if (redirect) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_q] <= mem_rdata;
         pc_q[wr_q]   <= mem_addr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with programmable wait states and a
// queue scoreboard checked by monitors on every consumed instruction.
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp5_q[$];
   int   checks = 0;
   int   errors = 0;

   // main instance, W=8
   logic        rst, instr_ready, redirect, force_ack;
   logic [7:0]  redirect_pc;
   logic [31:0] instr, mem_rdata;
   logic [7:0]  instr_pc, mem_addr;
   logic        instr_valid, mem_req, mem_ack, pc_end;
   int          wait_n = 0;
   int          wcnt = 0;

   assign mem_ack   = force_ack | (mem_req && (wcnt == wait_n));
   assign mem_rdata = 32'h13 + {24'h0, mem_addr};
   always @(posedge clk) begin
      if (!mem_req || mem_ack) wcnt <= 0;
      else                     wcnt <= wcnt + 1;
   end

   instr_fetch_unit #(.INSTR_ADDR_WIDTH(8), .FIFO_DEPTH(2), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .pc_end(pc_end));

   // second instance, W=5, zero-wait memory
   logic        rst5, ready5, redirect5;
   logic [4:0]  redirect_pc5, instr_pc5, mem_addr5;
   logic [31:0] instr5, mem_rdata5;
   logic        instr_valid5, mem_req5, mem_ack5, pc_end5;

   assign mem_ack5   = mem_req5;
   assign mem_rdata5 = 32'h13 + {27'h0, mem_addr5};

   instr_fetch_unit #(.INSTR_ADDR_WIDTH(5), .FIFO_DEPTH(2), .RESET_PC(5'h00)) dut5 (
      .clk(clk), .rst(rst5), .instr(instr5), .instr_pc(instr_pc5), .instr_valid(instr_valid5),
      .instr_ready(ready5), .redirect(redirect5), .redirect_pc(redirect_pc5),
      .mem_req(mem_req5), .mem_addr(mem_addr5), .mem_ack(mem_ack5), .mem_rdata(mem_rdata5),
      .pc_end(pc_end5));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] pc);
      exp_q.push_back('{32'h13 + {24'h0, pc}, pc});
   endtask

   task automatic push_exp5(input logic [7:0] pc);
      exp5_q.push_back('{32'h13 + {24'h0, pc}, pc});
   endtask

   task automatic reset_main();
      instr_ready = 1'b0;
      redirect    = 1'b0;
      force_ack   = 1'b0;
      rst         = 1'b1;
      step();
      step();
   endtask

   initial begin : mon_main
      exp_t e;
      forever begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_main: unexpected pc %0h instr %0h", instr_pc, instr);
            end else begin
               e = exp_q.pop_front();
               if (instr !== e.instr || instr_pc !== e.pc) begin
                  errors++;
                  $display("FAIL pop_main: got pc %0h instr %0h expected pc %0h instr %0h",
                           instr_pc, instr, e.pc, e.instr);
               end
            end
         end
      end
   end

   initial begin : mon_w5
      exp_t e;
      forever begin
         @(negedge clk);
         if (instr_valid5 && ready5) begin
            checks++;
            if (exp5_q.size() == 0) begin
               errors++;
               $display("FAIL pop_w5: unexpected pc %0h instr %0h", instr_pc5, instr5);
            end else begin
               e = exp5_q.pop_front();
               if (instr5 !== e.instr || {3'b0, instr_pc5} !== e.pc) begin
                  errors++;
                  $display("FAIL pop_w5: got pc %0h instr %0h expected pc %0h instr %0h",
                           instr_pc5, instr5, e.pc, e.instr);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int acks;
      rst5 = 1'b1; ready5 = 1'b0; redirect5 = 1'b0; redirect_pc5 = '0;
      redirect_pc = '0;

      // reset state
      reset_main();
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pc_end", pc_end, 0);

      // zero-wait streaming, one instruction per clock
      wait_n = 0;
      for (int i = 0; i < 6; i++) push_exp(8'(i));
      instr_ready = 1'b1;
      rst = 1'b0;
      step();
      chk("t1_req_lat", mem_req, 1);
      chk("t1_addr0", mem_addr, 0);
      step();
      for (int i = 0; i < 6; i++) begin
         chk("t1_valid", instr_valid, 1);
         step();
      end
      instr_ready = 1'b0;
      chk("t1_drained", exp_q.size(), 0);

      // two wait states: address held 3 cycles, valid duty 1/3
      reset_main();
      wait_n = 2;
      for (int i = 0; i < 3; i++) push_exp(8'(i));
      instr_ready = 1'b1;
      rst = 1'b0;
      step();
      for (int c = 0; c < 9; c++) begin
         chk("t2_req", mem_req, 1);
         chk("t2_addr", mem_addr, 32'(c / 3));
         chk("t2_valid", instr_valid, (c % 3 == 0 && c > 0) ? 1 : 0);
         step();
      end
      chk("t2_valid_last", instr_valid, 1);
      step();
      instr_ready = 1'b0;
      chk("t2_drained", exp_q.size(), 0);

      // backpressure: only FIFO_DEPTH words fetched while stalled
      reset_main();
      wait_n = 0;
      for (int i = 0; i < 5; i++) push_exp(8'(i));
      rst = 1'b0;
      acks = 0;
      step();
      for (int c = 0; c < 10; c++) begin
         if (mem_req && mem_ack) acks++;
         step();
      end
      chk("t3_acks", acks, 2);
      chk("t3_req_idle", mem_req, 0);
      chk("t3_valid_held", instr_valid, 1);
      instr_ready = 1'b1;
      step();
      chk("t3_req_resume", mem_req, 1);
      chk("t3_addr_resume", mem_addr, 2);
      repeat (4) step();
      instr_ready = 1'b0;
      chk("t3_drained", exp_q.size(), 0);

      // redirect while fetch of 0x05 is outstanding
      reset_main();
      wait_n = 2;
      for (int i = 0; i < 5; i++) push_exp(8'(i));
      push_exp(8'h20);
      push_exp(8'h21);
      instr_ready = 1'b1;
      rst = 1'b0;
      step();
      repeat (16) step();
      chk("t4_out_req", mem_req, 1);
      chk("t4_out_addr", mem_addr, 5);
      redirect = 1'b1;
      redirect_pc = 8'h20;
      step();
      redirect = 1'b0;
      chk("t4_flush_valid", instr_valid, 0);
      chk("t4_addr_held", mem_addr, 5);
      step();
      chk("t4_drop_valid", instr_valid, 0);
      chk("t4_new_addr", mem_addr, 8'h20);
      chk("t4_new_req", mem_req, 1);
      repeat (7) step();
      instr_ready = 1'b0;
      chk("t4_drained", exp_q.size(), 0);

      // W=5: run to the last word, pc_end, then redirect back to 0
      for (int i = 0; i < 32; i++) push_exp5(8'(i));
      ready5 = 1'b1;
      rst5 = 1'b0;
      step();
      repeat (31) step();
      chk("t5_req_last", mem_req5, 1);
      chk("t5_addr_last", mem_addr5, 31);
      step();
      chk("t5_req_stop", mem_req5, 0);
      chk("t5_pc_end_early", pc_end5, 0);
      chk("t5_valid_last", instr_valid5, 1);
      step();
      chk("t5_pc_end", pc_end5, 1);
      chk("t5_valid_empty", instr_valid5, 0);
      chk("t5_req_done", mem_req5, 0);
      step();
      step();
      chk("t5_pc_end_held", pc_end5, 1);
      push_exp5(8'h00);
      push_exp5(8'h01);
      redirect5 = 1'b1;
      redirect_pc5 = 5'h00;
      step();
      redirect5 = 1'b0;
      chk("t5_pc_end_clr", pc_end5, 0);
      chk("t5_restart_req", mem_req5, 1);
      chk("t5_restart_addr", mem_addr5, 0);
      repeat (3) step();
      ready5 = 1'b0;
      chk("t5_drained", exp5_q.size(), 0);

      // reset in the middle of a wait-stated fetch, late ack ignored
      reset_main();
      wait_n = 2;
      rst = 1'b0;
      step();
      repeat (4) step();
      chk("t6_pre_valid", instr_valid, 1);
      chk("t6_pre_req", mem_req, 1);
      chk("t6_pre_addr", mem_addr, 1);
      rst = 1'b1;
      step();
      chk("t6_rst_valid", instr_valid, 0);
      chk("t6_rst_req", mem_req, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_instr", instr, 0);
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      chk("t6_late_ack", instr_valid, 0);
      push_exp(8'h00);
      instr_ready = 1'b1;
      rst = 1'b0;
      step();
      chk("t6_refetch_req", mem_req, 1);
      chk("t6_refetch_addr", mem_addr, 0);
      repeat (3) step();
      chk("t6_refetch_valid", instr_valid, 1);
      step();
      instr_ready = 1'b0;
      chk("t6_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
